// File: rtl/cpu_pkg.sv
// Shared types for the SCCPU pipeline control path:
// forwarding-select encodings, hazard FSM states, register address width.
package cpu_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_LD  = 2'b11;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: adds one per cycle while inc is high, sticks at all-ones.
// Ports: Clock, Resetn (async active-low), inc in, count out [CNT_W-1:0].
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q))
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipeline: forwarding selects,
// load-use stall, data-memory wait freeze with timeout, redirect flush, perf counters.
// Ports: Clock/Resetn; ID/EXE/MEM register info in; mem_req/dmem_ready/exe_redirect in;
// fwda/fwdb, wpcir, id_bubble, if_flush, freeze, mem_err, stall_cnt, flush_cnt out.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = cpu_pkg::REG_AW,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              exe_wreg,
  input  logic              exe_m2reg,
  input  logic [REG_AW-1:0] exe_rd,
  input  logic              mem_wreg,
  input  logic              mem_m2reg,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_req,
  input  logic              dmem_ready,
  input  logic              exe_redirect,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              wpcir,
  output logic              id_bubble,
  output logic              if_flush,
  output logic              freeze,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  import cpu_pkg::*;

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TO_LAST = WW'(MEM_TIMEOUT - 1);

  hz_state_e     state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
  logic          frz_c;
  logic          lu;
  logic          redir;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] r,
    input logic              ew,
    input logic              em,
    input logic [REG_AW-1:0] erd,
    input logic              mw,
    input logic              mm,
    input logic [REG_AW-1:0] mrd
  );
    logic [1:0] s;
    s = FWD_RF;
    if (r == '0)
      s = FWD_RF;
    else if (ew && !em && erd == r)
      s = FWD_EXE;
    else if (mw && mrd == r)
      s = mm ? FWD_LD : FWD_MEM;
    return s;
  endfunction

  always_comb begin
    fwda = fwd_sel(id_rs, exe_wreg, exe_m2reg, exe_rd,
                   mem_wreg, mem_m2reg, mem_rd);
    fwdb = fwd_sel(id_rt, exe_wreg, exe_m2reg, exe_rd,
                   mem_wreg, mem_m2reg, mem_rd);
  end

  assign lu = exe_wreg && exe_m2reg && exe_rd != '0 &&
              ((id_use_rs && id_rs == exe_rd) ||
               (id_use_rt && id_rt == exe_rd));

  // Wait FSM. The wait counter holds the number of MEM_WAIT cycles
  // already spent; the last allowed one releases the freeze.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    frz_c   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req && !dmem_ready) begin
          frz_c   = 1'b1;
          state_d = MEM_WAIT;
          wcnt_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = RUN;
          wcnt_d  = '0;
        end else begin
          frz_c  = 1'b1;
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Reset must release a frozen pipeline even if mem_req is still high.
  assign freeze = frz_c && Resetn;
  assign redir  = exe_redirect && !freeze;

  always_comb begin
    wpcir     = 1'b1;
    id_bubble = 1'b0;
    if_flush  = 1'b0;
    unique case (1'b1)
      freeze: begin
        wpcir = 1'b0;
      end
      redir: begin
        if_flush  = 1'b1;
        id_bubble = 1'b1;
      end
      (!freeze && !exe_redirect && lu): begin
        wpcir     = 1'b0;
        id_bubble = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_err = err_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clock  (Clock),
    .Resetn (Resetn),
    .inc    (!wpcir || freeze),
    .count  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clock  (Clock),
    .Resetn (Resetn),
    .inc    (redir),
    .count  (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use,
// memory wait/timeout, redirect, async reset and counter saturation.
module tb_pipe_hazard_ctrl;

  logic        Clock;
  logic        Resetn;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt;
  logic        exe_wreg, exe_m2reg;
  logic [4:0]  exe_rd;
  logic        mem_wreg, mem_m2reg;
  logic [4:0]  mem_rd;
  logic        mem_req, dmem_ready, exe_redirect;
  logic [1:0]  fwda, fwdb;
  logic        wpcir, id_bubble, if_flush, freeze, mem_err;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int fails  = 0;

  pipe_hazard_ctrl #(
    .REG_AW      (5),
    .MEM_TIMEOUT (15),
    .CNT_W       (16)
  ) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .exe_wreg     (exe_wreg),
    .exe_m2reg    (exe_m2reg),
    .exe_rd       (exe_rd),
    .mem_wreg     (mem_wreg),
    .mem_m2reg    (mem_m2reg),
    .mem_rd       (mem_rd),
    .mem_req      (mem_req),
    .dmem_ready   (dmem_ready),
    .exe_redirect (exe_redirect),
    .fwda         (fwda),
    .fwdb         (fwdb),
    .wpcir        (wpcir),
    .id_bubble    (id_bubble),
    .if_flush     (if_flush),
    .freeze       (freeze),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs        = '0;
    id_rt        = '0;
    id_use_rs    = 1'b0;
    id_use_rt    = 1'b0;
    exe_wreg     = 1'b0;
    exe_m2reg    = 1'b0;
    exe_rd       = '0;
    mem_wreg     = 1'b0;
    mem_m2reg    = 1'b0;
    mem_rd       = '0;
    mem_req      = 1'b0;
    dmem_ready   = 1'b1;
    exe_redirect = 1'b0;
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    Resetn = 1'b0;
    #2;
    @(negedge Clock);
    Resetn = 1'b1;
    cyc();
  endtask

  task automatic set_lu_rt4();
    exe_wreg  = 1'b1;
    exe_m2reg = 1'b1;
    exe_rd    = 5'd4;
    id_rt     = 5'd4;
    id_use_rt = 1'b1;
  endtask

  initial begin
    idle();
    Resetn = 1'b0;
    #3;
    chk("rst_freeze", 32'(freeze), 0);
    chk("rst_wpcir",  32'(wpcir), 1);
    chk("rst_err",    32'(mem_err), 0);
    chk("rst_stall",  32'(stall_cnt), 0);
    chk("rst_flush",  32'(flush_cnt), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    cyc();

    // forwarding
    exe_wreg = 1'b1; exe_rd = 5'd3;
    id_rs = 5'd3; id_use_rs = 1'b1;
    settle();
    chk("fwd_exe_a", 32'(fwda), 32'h1);
    chk("fwd_exe_wpcir", 32'(wpcir), 1);
    cyc();
    exe_wreg = 1'b0; exe_rd = 5'd0;
    mem_wreg = 1'b1; mem_rd = 5'd3;
    settle();
    chk("fwd_mem_a", 32'(fwda), 32'h2);
    cyc();
    id_rs = 5'd0; mem_rd = 5'd0;
    exe_wreg = 1'b1; exe_rd = 5'd0;
    settle();
    chk("fwd_r0_a", 32'(fwda), 32'h0);
    cyc();
    idle();
    exe_wreg = 1'b1; exe_rd = 5'd5;
    mem_wreg = 1'b1; mem_m2reg = 1'b1; mem_rd = 5'd5;
    id_rt = 5'd5;
    settle();
    chk("fwd_prio_b", 32'(fwdb), 32'h1);
    cyc();
    exe_rd = 5'd6;
    settle();
    chk("fwd_ld_b", 32'(fwdb), 32'h3);
    chk("fwd_ld_a", 32'(fwda), 32'h0);
    cyc();
    idle();
    exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_rd = 5'd0;
    id_rt = 5'd0; id_use_rt = 1'b1;
    settle();
    chk("lu_r0_wpcir", 32'(wpcir), 1);
    exe_rd = 5'd7; id_rt = 5'd7; id_use_rt = 1'b0;
    settle();
    chk("lu_nouse_wpcir", 32'(wpcir), 1);
    chk("fwd_stall0", 32'(stall_cnt), 0);

    // load-use
    do_reset();
    set_lu_rt4();
    settle();
    chk("lu_wpcir",  32'(wpcir), 0);
    chk("lu_bubble", 32'(id_bubble), 1);
    chk("lu_flush",  32'(if_flush), 0);
    cyc();
    idle();
    mem_wreg = 1'b1; mem_m2reg = 1'b1; mem_rd = 5'd4;
    id_rt = 5'd4; id_use_rt = 1'b1;
    settle();
    chk("lu2_fwdb",  32'(fwdb), 32'h3);
    chk("lu2_wpcir", 32'(wpcir), 1);
    chk("lu2_stall", 32'(stall_cnt), 1);

    // memory wait, redirect masked by freeze
    do_reset();
    mem_req = 1'b1; dmem_ready = 1'b0;
    exe_redirect = 1'b1;
    set_lu_rt4();
    settle();
    chk("mw0_freeze", 32'(freeze), 1);
    chk("mw0_wpcir",  32'(wpcir), 0);
    chk("mw0_flush",  32'(if_flush), 0);
    chk("mw0_bubble", 32'(id_bubble), 0);
    cyc();
    exe_redirect = 1'b0;
    idle();
    mem_req = 1'b1; dmem_ready = 1'b0;
    settle();
    chk("mw1_freeze", 32'(freeze), 1);
    cyc();
    settle();
    chk("mw2_freeze", 32'(freeze), 1);
    cyc();
    dmem_ready = 1'b1;
    settle();
    chk("mw3_freeze", 32'(freeze), 0);
    chk("mw3_wpcir",  32'(wpcir), 1);
    cyc();
    mem_req = 1'b0;
    settle();
    chk("mw_stall", 32'(stall_cnt), 3);
    chk("mw_flushc", 32'(flush_cnt), 0);
    chk("mw_err", 32'(mem_err), 0);

    // redirect beats load-use
    do_reset();
    set_lu_rt4();
    exe_redirect = 1'b1;
    settle();
    chk("rd_flush",  32'(if_flush), 1);
    chk("rd_bubble", 32'(id_bubble), 1);
    chk("rd_wpcir",  32'(wpcir), 1);
    cyc();
    idle();
    settle();
    chk("rd_flushc", 32'(flush_cnt), 1);
    chk("rd_stall",  32'(stall_cnt), 0);

    // timeout
    do_reset();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      settle();
      chk($sformatf("to_frz%0d", i), 32'(freeze), 1);
      cyc();
    end
    settle();
    chk("to_release", 32'(freeze), 0);
    chk("to_err_pre", 32'(mem_err), 0);
    mem_req = 1'b0;
    cyc();
    chk("to_err", 32'(mem_err), 1);
    chk("to_stall", 32'(stall_cnt), 15);
    chk("to_frz_after", 32'(freeze), 0);
    repeat (3) cyc();
    chk("to_err_sticky", 32'(mem_err), 1);

    // async reset in MEM_WAIT
    mem_req = 1'b1; dmem_ready = 1'b0;
    cyc();
    cyc();
    chk("ar_pre_frz", 32'(freeze), 1);
    Resetn = 1'b0;
    settle();
    chk("ar_freeze", 32'(freeze), 0);
    chk("ar_err",    32'(mem_err), 0);
    chk("ar_stall",  32'(stall_cnt), 0);
    chk("ar_flushc", 32'(flush_cnt), 0);
    idle();
    @(negedge Clock);
    Resetn = 1'b1;
    cyc();

    // saturation
    do_reset();
    set_lu_rt4();
    repeat (65534) cyc();
    chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    cyc();
    chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
    repeat (5) cyc();
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
    chk("sat_wpcir", 32'(wpcir), 0);
    chk("sat_flushc", 32'(flush_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
